clear_seq_ctrl: RTL and testbench
=================================

Name: clear_seq_ctrl

Overview:
Push-button clear controller for the calculator core. It samples the raw 2-bit C/AC button code, debounces it, and turns each press into a single command. It then sequences the clear operations on the core datapath over a req/ack handshake: C clears the current entry; AC clears entry, accumulator and display in order. It is the only block that drives the core's clear interface.

Parameters:
DEB_CYCLES, 4, consecutive identical samples required before a button code is accepted (2..15)
TO_CYCLES, 255, max cycles a request may wait for core_ack before abort (1..255)

Ports:
clk  input  1  system clock
rst  input  1  module reset, asynchronous, active-low
sel  input  1  module selection; low blocks acceptance of new presses
btn_code  input  2  raw button code: 00 none, 01 AC, 10 C, 11 both
core_ack  input  1  core completed the current clear step
clr_req  output  1  clear request to core
clr_op  output  2  clear step: 01 entry, 10 accumulator, 11 display; 00 when idle
busy  output  1  sequence in progress (state != IDLE)
done  output  1  one-cycle pulse when a sequence completes normally
err  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): clr_req=0, clr_op=00, busy=0, done=0, err=0, FSM=IDLE, debounce count=0, last-sample=00, armed=1, pending_ac=0.
- Debounce: btn_code is registered each clk. If the new sample equals the previous sample, the count increments, saturating at DEB_CYCLES. Otherwise the count is set to 1.
- The code is stable when count==DEB_CYCLES.
- A stable 00 sets armed=1.
- A stable non-zero code with armed=1 and sel=1 produces a press event in that cycle and clears armed. One event per press; the button must return to a stable 00 before the next event.
- Code 11 is treated as AC (AC priority).
- Press event in IDLE: the FSM enters ISSUE on the next edge. Sequence list: C={entry}; AC={entry, accumulator, display}.
- ISSUE: clr_req=1, clr_op=current step. The timeout counter resets on entry and increments each cycle.
  - core_ack=1 sampled → clr_req drops next edge. Go to GAP if steps remain, else DONE.
  - Timeout counter reaching TO_CYCLES with no ack → err=1, clr_req=0, pending_ac=0, go to IDLE. No done pulse.
- GAP: one cycle with clr_req=0, then ISSUE with the next step. Ack is ignored outside ISSUE.
- DONE: done=1 for exactly one cycle.
  - If pending_ac=1: clear pending_ac and go to ISSUE starting the AC sequence.
  - Otherwise go to IDLE.
- Press events while busy:
  - AC during a C sequence sets pending_ac.
  - C at any time while busy is discarded.
  - AC during an AC sequence is discarded.
  - pending_ac holds at most one command.
- sel=0 suppresses press events (armed still updates) but never interrupts a running sequence.
- err clears only on reset. While err=1 the block keeps operating normally.
- Async reset mid-sequence drops clr_req immediately, with no completion of the step.
- clr_op changes only on edges where clr_req rises or in IDLE (00). It is stable while clr_req=1.

Test Plan:
1. Reset release, btn_code=10 held for 6 cycles, core_ack pulsed 2 cycles after clr_req rises → exactly one clr_req with clr_op=01, done pulse 1 cycle, busy back to 0; held button produces no second event.
2. btn_code=01 held, core_ack answered each ISSUE after 1 cycle → clr_op sequence 01, 10, 11, each separated by one cycle of clr_req=0; one done pulse at end.
3. Bounce: btn_code toggles 10/00 every cycle for 10 cycles, then 00 → no clr_req ever; then 01 stable 3 cycles with DEB_CYCLES=4 → no event; 4th identical sample → event.
4. During a C sequence (ack withheld), press AC (stable 4 cycles, after a stable 00) → after C's done, the AC sequence 01/10/11 starts without a new press; done pulses twice in total.
5. Press C, never ack, TO_CYCLES=8 → clr_req high exactly 8 cycles, then err=1, busy=0, no done; next C press runs normally with err still 1.
6. sel=0 with stable 10 → no event; assert rst low mid-ISSUE → clr_req, clr_op, busy, err go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/clear_seq_ctrl.sv
// Clear controller for the calculator core: debounces the C/AC button code
// and sequences entry/accumulator/display clears over a req/ack handshake.
module clear_seq_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int TO_CYCLES  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic [1:0] btn_code,
    input  logic       core_ack,
    output logic       clr_req,
    output logic [1:0] clr_op,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [3:0] DEB_MAX = 4'(DEB_CYCLES);
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
    localparam logic [1:0] OP_ENTRY = 2'b01;
    localparam logic [1:0] OP_DISP  = 2'b11;

    logic [1:0] sample_q;
    logic [3:0] debCnt_q, debCnt_d;
    logic       armed_q, armed_d;
    logic       stable, pressEv, pressAc;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       isAc_q, isAc_d;
    logic       pendingAc_q, pendingAc_d;
    logic [7:0] toCnt_q, toCnt_d;
    logic       err_q, err_d;

    // Debounce: a code counts as stable once DEB_CYCLES identical samples are seen;
    // a press fires once per stable non-zero code and re-arms on a stable release.
    always_comb begin
        debCnt_d = 4'd1;
        if (btn_code == sample_q) begin
            debCnt_d = (debCnt_q == DEB_MAX) ? debCnt_q : debCnt_q + 4'd1;
        end
        stable  = (debCnt_q == DEB_MAX);
        pressEv = stable && (sample_q != 2'b00) && armed_q && sel;
        pressAc = pressEv && sample_q[0];
        armed_d = armed_q;
        if (stable && (sample_q == 2'b00)) begin
            armed_d = 1'b1;
        end else if (pressEv) begin
            armed_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        isAc_d      = isAc_q;
        pendingAc_d = pendingAc_q;
        toCnt_d     = toCnt_q;
        err_d       = err_q;

        if (pressAc && (state_q != S_IDLE) && !isAc_q) begin
            pendingAc_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                op_d = 2'b00;
                if (pressEv) begin
                    state_d = S_ISSUE;
                    op_d    = OP_ENTRY;
                    isAc_d  = pressAc;
                    toCnt_d = 8'd0;
                end
            end
            S_ISSUE: begin
                toCnt_d = toCnt_q + 8'd1;
                if (core_ack) begin
                    state_d = (isAc_q && (op_q != OP_DISP)) ? S_GAP : S_DONE;
                end else if (toCnt_q == TO_LAST) begin
                    state_d     = S_IDLE;
                    op_d        = 2'b00;
                    err_d       = 1'b1;
                    pendingAc_d = 1'b0;
                end
            end
            S_GAP: begin
                state_d = S_ISSUE;
                op_d    = op_q + 2'd1;
                toCnt_d = 8'd0;
            end
            S_DONE: begin
                // An AC arriving in this very cycle is honoured the same as a queued one.
                if (pendingAc_q || (pressAc && !isAc_q)) begin
                    state_d     = S_ISSUE;
                    op_d        = OP_ENTRY;
                    isAc_d      = 1'b1;
                    pendingAc_d = 1'b0;
                    toCnt_d     = 8'd0;
                end else begin
                    state_d = S_IDLE;
                    op_d    = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
                op_d    = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q    <= 2'b00;
            debCnt_q    <= 4'd0;
            armed_q     <= 1'b1;
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            isAc_q      <= 1'b0;
            pendingAc_q <= 1'b0;
            toCnt_q     <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            sample_q    <= btn_code;
            debCnt_q    <= debCnt_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            op_q        <= op_d;
            isAc_q      <= isAc_d;
            pendingAc_q <= pendingAc_d;
            toCnt_q     <= toCnt_d;
            err_q       <= err_d;
        end
    end

    assign clr_req = (state_q == S_ISSUE);
    assign clr_op  = op_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_clear_seq_ctrl.sv
// Scoreboard bench for clear_seq_ctrl: directed button sequences push expected
// handshake events; a monitor pops and compares each event the DUT produces.
module tb_clear_seq_ctrl;

    localparam int DEB = 4;
    localparam int TO  = 12;
    localparam logic [15:0] EV_DONE = 16'h3000;
    localparam logic [15:0] EV_ERR  = 16'h4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [1:0] btn_code;
    logic       core_ack;
    logic       clr_req;
    logic [1:0] clr_op;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int ackDelay = -1;
    logic [15:0] expQ[$];

    clear_seq_ctrl #(.DEB_CYCLES(DEB), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .sel(sel), .btn_code(btn_code), .core_ack(core_ack),
        .clr_req(clr_req), .clr_op(clr_op), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] evReq(input int gap, input logic [1:0] op);
        return {4'h1, 4'h0, 4'(gap), 2'b00, op};
    endfunction

    function automatic logic [15:0] evFall(input int len);
        return {8'h20, 8'(len)};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic observeEvent(input logic [15:0] got);
        logic [15:0] want;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event actual=%h expected=none", got);
        end else begin
            want = expQ.pop_front();
            checkOutput("event", got, want);
        end
    endtask

    task automatic checkQueueEmpty(input string name);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s missing_events actual=%0d expected=0 next=%h", name, expQ.size(), expQ[0]);
            expQ.delete();
        end
    endtask

    task automatic applyStimulus(input logic [1:0] code, input int cycles);
        btn_code = code;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pushAcSequence(input int firstGap, input int highLen);
        expQ.push_back(evReq(firstGap, 2'b01));
        expQ.push_back(evFall(highLen));
        expQ.push_back(evReq(1, 2'b10));
        expQ.push_back(evFall(highLen));
        expQ.push_back(evReq(1, 2'b11));
        expQ.push_back(evFall(highLen));
        expQ.push_back(EV_DONE);
    endtask

    // Core model: acks ackDelay cycles after the request is first seen; negative never acks.
    initial begin
        int waitCnt;
        waitCnt  = 0;
        core_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && clr_req && !core_ack && ackDelay >= 0) begin
                if (waitCnt >= ackDelay) core_ack = 1'b1;
                else waitCnt++;
            end else begin
                core_ack = 1'b0;
                waitCnt  = 0;
            end
        end
    end

    // Monitor: turns request edges, done pulses and err rising into events.
    initial begin
        logic       prevReq;
        logic       prevErr;
        logic [1:0] prevOp;
        int         highLen;
        int         lowRun;
        prevReq = 1'b0; prevErr = 1'b0; prevOp = 2'b00; highLen = 0; lowRun = 3;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prevReq = 1'b0; prevErr = 1'b0; highLen = 0; lowRun = 3;
            end else begin
                if (!clr_req) begin
                    if (prevReq) begin
                        observeEvent(evFall(highLen));
                        lowRun = 0;
                    end
                    if (lowRun < 3) lowRun++;
                end
                if (done) observeEvent(EV_DONE);
                if (err && !prevErr) observeEvent(EV_ERR);
                if (clr_req) begin
                    if (!prevReq) begin
                        observeEvent(evReq(lowRun, clr_op));
                        highLen = 0;
                    end else begin
                        checkOutput("op_stable", 16'(clr_op), 16'(prevOp));
                    end
                    highLen++;
                end
                prevReq = clr_req;
                prevErr = err;
                prevOp  = clr_op;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        sel      = 1'b1;
        btn_code = 2'b00;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_clr_req", 16'(clr_req), 16'd0);
        checkOutput("rst_clr_op", 16'(clr_op), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);
        checkOutput("rst_err", 16'(err), 16'd0);
        rst = 1'b1;

        // C press held 6 cycles, ack two cycles after the request rises.
        ackDelay = 2;
        expQ.push_back(evReq(3, 2'b01));
        expQ.push_back(evFall(3));
        expQ.push_back(EV_DONE);
        applyStimulus(2'b00, 6);
        applyStimulus(2'b10, 6);
        applyStimulus(2'b00, 20);
        checkQueueEmpty("c_single");
        checkOutput("c_busy_end", 16'(busy), 16'd0);

        // AC press: three steps each separated by one idle cycle.
        ackDelay = 1;
        pushAcSequence(3, 2);
        applyStimulus(2'b01, 6);
        applyStimulus(2'b00, 20);
        checkQueueEmpty("ac_seq");

        // Bouncing input never settles, then exactly DEB samples are required.
        for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 2'b10 : 2'b00, 1);
        applyStimulus(2'b00, 6);
        checkQueueEmpty("bounce");
        pushAcSequence(3, 2);
        applyStimulus(2'b01, DEB);
        checkOutput("deb_not_early", 16'(busy), 16'd0);
        applyStimulus(2'b01, 1);
        checkOutput("deb_accept", 16'(busy), 16'd1);
        applyStimulus(2'b00, 20);
        checkQueueEmpty("deb_ac");

        // AC pressed while a slow C is in flight runs right after C's done.
        ackDelay = 9;
        expQ.push_back(evReq(3, 2'b01));
        expQ.push_back(evFall(10));
        expQ.push_back(EV_DONE);
        pushAcSequence(1, 10);
        applyStimulus(2'b00, 6);
        applyStimulus(2'b10, 4);
        applyStimulus(2'b00, 4);
        applyStimulus(2'b01, 4);
        applyStimulus(2'b00, 50);
        checkQueueEmpty("pending_ac");

        // No ack: request held TO cycles, then sticky err and no done.
        ackDelay = -1;
        expQ.push_back(evReq(3, 2'b01));
        expQ.push_back(evFall(TO));
        expQ.push_back(EV_ERR);
        applyStimulus(2'b10, 4);
        applyStimulus(2'b00, 20);
        checkQueueEmpty("timeout");
        checkOutput("timeout_err", 16'(err), 16'd1);
        checkOutput("timeout_busy", 16'(busy), 16'd0);
        ackDelay = 1;
        expQ.push_back(evReq(3, 2'b01));
        expQ.push_back(evFall(2));
        expQ.push_back(EV_DONE);
        applyStimulus(2'b10, 4);
        applyStimulus(2'b00, 10);
        checkQueueEmpty("after_timeout");
        checkOutput("err_sticky", 16'(err), 16'd1);

        // sel low blocks presses; async reset mid-request clears outputs at once.
        sel = 1'b0;
        applyStimulus(2'b10, 8);
        applyStimulus(2'b00, 6);
        sel = 1'b1;
        checkOutput("sel_block", 16'(busy), 16'd0);
        checkQueueEmpty("sel_low");
        ackDelay = -1;
        expQ.push_back(evReq(3, 2'b01));
        applyStimulus(2'b10, 4);
        btn_code = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("issue_before_rst", 16'(clr_req), 16'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_clr_req", 16'(clr_req), 16'd0);
        checkOutput("arst_clr_op", 16'(clr_op), 16'd0);
        checkOutput("arst_busy", 16'(busy), 16'd0);
        checkOutput("arst_err", 16'(err), 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'b00, 6);
        checkQueueEmpty("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
